// File: rtl/rv_plic_irq_dispatch_if.sv
// Core-side interrupt handshake between the PLIC dispatcher and a hart.
// The dispatcher drives the offer; the core answers with accept and done.
interface rv_plic_irq_dispatch_if #(
  parameter int NumSrc = 32
);
  localparam int SRCW = $clog2(NumSrc);

  logic            req_valid_o;
  logic [SRCW-1:0] req_id_o;
  logic            req_ready_i;
  logic            done_valid_i;
  logic [SRCW-1:0] done_id_i;

  modport master (
    output req_valid_o,
    output req_id_o,
    input  req_ready_i,
    input  done_valid_i,
    input  done_id_i
  );

  modport slave (
    input  req_valid_o,
    input  req_id_o,
    output req_ready_i,
    output done_valid_i,
    output done_id_i
  );
endinterface

// File: rtl/rv_plic_irq_dispatch.sv
// Per-target PLIC claim/complete sequencer with settle, offer and timeout.
// Optional counters under macro RV_PLIC_DISPATCH_STATS_EN.
module rv_plic_irq_dispatch #(
  parameter int  NumSrc        = 32,
  parameter int  SettleCycles  = 2,
  parameter int  TimeoutCycles = 1024,
  localparam int SRCW          = $clog2(NumSrc)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            irq_i,
  input  logic [SRCW:0]   irq_id_i,
  output logic            claim_o,
  output logic [SRCW-1:0] claim_id_o,
  output logic            complete_o,
  output logic [SRCW-1:0] complete_id_o,
  output logic            busy_o,
  output logic            timeout_o,
  output logic            id_err_o,
  rv_plic_irq_dispatch_if.master core
`ifdef RV_PLIC_DISPATCH_STATS_EN
  ,
  output logic [15:0]     dispatch_cnt_o,
  output logic [7:0]      timeout_cnt_o
`endif
);

  localparam int TW =
    (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [3:0] SLAST = 4'(SettleCycles - 1);
  localparam logic [TW-1:0] TLAST =
    TW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    OFFER,
    CLAIM,
    SERVICE,
    COMPLETE
  } state_e;

  state_e          state;
  logic [SRCW-1:0] id_q;
  logic [3:0]      scnt;
  logic [TW-1:0]   tcnt;

  logic nz_id;
  logic same_id;
  logic done_hit;
  logic t_expire;

  // Input qualifiers against the latched source ID
  always_comb begin
    nz_id    = (irq_id_i != '0);
    same_id  = irq_i && (irq_id_i == {1'b0, id_q});
    done_hit = core.done_valid_i && (core.done_id_i == id_q);
    t_expire = (TimeoutCycles != 0) && (tcnt == TLAST);
  end

  // Sequencer: settle, offer, claim, service, complete
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      id_q             <= '0;
      scnt             <= '0;
      tcnt             <= '0;
      claim_o          <= 1'b0;
      claim_id_o       <= '0;
      complete_o       <= 1'b0;
      complete_id_o    <= '0;
      busy_o           <= 1'b0;
      timeout_o        <= 1'b0;
      id_err_o         <= 1'b0;
      core.req_valid_o <= 1'b0;
      core.req_id_o    <= '0;
`ifdef RV_PLIC_DISPATCH_STATS_EN
      dispatch_cnt_o   <= '0;
      timeout_cnt_o    <= '0;
`endif
    end else begin
      claim_o    <= 1'b0;
      complete_o <= 1'b0;
      id_err_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (irq_i && nz_id) begin
            id_q  <= irq_id_i[SRCW-1:0];
            scnt  <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (!irq_i || !nz_id) begin
            state <= IDLE;
          end else if (!same_id) begin
            id_q <= irq_id_i[SRCW-1:0];
            scnt <= '0;
          end else if (scnt == SLAST) begin
            core.req_valid_o <= 1'b1;
            core.req_id_o    <= id_q;
            state            <= OFFER;
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        OFFER: begin
          if (core.req_ready_i) begin
            core.req_valid_o <= 1'b0;
            claim_o          <= 1'b1;
            claim_id_o       <= id_q;
            busy_o           <= 1'b1;
            state            <= CLAIM;
`ifdef RV_PLIC_DISPATCH_STATS_EN
            dispatch_cnt_o   <= dispatch_cnt_o + 16'd1;
`endif
          end else if (!same_id) begin
            core.req_valid_o <= 1'b0;
            state            <= IDLE;
          end
        end
        CLAIM: begin
          tcnt  <= '0;
          state <= SERVICE;
        end
        SERVICE: begin
          if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
          if (done_hit) begin
            complete_o    <= 1'b1;
            complete_id_o <= id_q;
            state         <= COMPLETE;
          end else begin
            if (core.done_valid_i) begin
              id_err_o <= 1'b1;
            end
            if (t_expire) begin
              timeout_o     <= 1'b1;
              complete_o    <= 1'b1;
              complete_id_o <= id_q;
              state         <= COMPLETE;
`ifdef RV_PLIC_DISPATCH_STATS_EN
              if (timeout_cnt_o != 8'hFF) begin
                timeout_cnt_o <= timeout_cnt_o + 8'd1;
              end
`endif
            end
          end
        end
        COMPLETE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_plic_irq_dispatch.sv
// Randomized directed bench for the PLIC claim/complete sequencer.
// Expected timing comes from transaction-level cycle arithmetic.
module tb_rv_plic_irq_dispatch;

  localparam int N = 32;
  localparam int W = $clog2(N);
  localparam int S = 2;
  localparam int T = 16;

  logic         clk;
  logic         rst_n;
  logic         irq;
  logic [W:0]   irq_id;
  logic         claim;
  logic [W-1:0] claim_id;
  logic         complete;
  logic [W-1:0] complete_id;
  logic         busy;
  logic         timeout;
  logic         id_err;
`ifdef RV_PLIC_DISPATCH_STATS_EN
  logic [15:0]  dispatch_cnt;
  logic [7:0]   timeout_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n_claim = 0;
  int n_to = 0;
  bit exp_to = 0;

  rv_plic_irq_dispatch_if #(.NumSrc(N)) core_if ();

  rv_plic_irq_dispatch #(
    .NumSrc(N),
    .SettleCycles(S),
    .TimeoutCycles(T)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .irq_i(irq),
    .irq_id_i(irq_id),
    .claim_o(claim),
    .claim_id_o(claim_id),
    .complete_o(complete),
    .complete_id_o(complete_id),
    .busy_o(busy),
    .timeout_o(timeout),
    .id_err_o(id_err),
    .core(core_if.master)
`ifdef RV_PLIC_DISPATCH_STATS_EN
    ,
    .dispatch_cnt_o(dispatch_cnt),
    .timeout_cnt_o(timeout_cnt)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // claim and complete must never coincide
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(claim === 1'b1 && complete === 1'b1)) else begin
        errors++;
        $error("FAIL overlap observed=%0b%0b expected=00",
               claim, complete);
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_claim"}, 32'(claim), 0);
    chk({tag, "_complete"}, 32'(complete), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(core_if.req_valid_o), 0);
    chk({tag, "_iderr"}, 32'(id_err), 0);
  endtask

  // One full dispatch: settle (optional glitch), offer, claim, service
  task automatic txn(input int id, input int id2, input int g,
                     input int rdly, input bit drop_acc,
                     input int jmis, input int jdone);
    int fid;
    int vedge;
    int mis;
    bit exp_c;
    fid = id;
    vedge = (g != 0) ? g + S : S;
    irq = 1;
    irq_id = (W+1)'(id);
    for (int k = 0; k <= vedge; k++) begin
      tick();
      chk("settle_valid", 32'(core_if.req_valid_o), 32'(k == vedge));
      chk("settle_busy", 32'(busy), 0);
      if (g != 0 && k == g - 1) begin
        irq_id = (W+1)'(id2);
        fid = id2;
      end
    end
    chk("req_id", 32'(core_if.req_id_o), 32'(fid));
    for (int r = 0; r < rdly; r++) begin
      tick();
      chk("offer_hold", 32'(core_if.req_valid_o), 1);
      chk("offer_noclaim", 32'(claim), 0);
    end
    core_if.req_ready_i = 1;
    if (drop_acc) irq = 0;
    tick();
    n_claim++;
    chk("claim", 32'(claim), 1);
    chk("claim_id", 32'(claim_id), 32'(fid));
    chk("claim_busy", 32'(busy), 1);
    chk("claim_valid", 32'(core_if.req_valid_o), 0);
    core_if.req_ready_i = 0;
    irq = 0;
    irq_id = '0;
    tick();
    chk("svc_claim", 32'(claim), 0);
    chk("svc_busy", 32'(busy), 1);
    mis = (fid == 3) ? 4 : 3;
    for (int m = 1; m <= T; m++) begin
      core_if.done_valid_i = (m == jdone) || (m == jmis);
      core_if.done_id_i = W'((m == jdone) ? fid : mis);
      tick();
      core_if.done_valid_i = 0;
      exp_c = (m == jdone) || (jdone == 0 && m == T);
      if (exp_c && jdone == 0) begin
        exp_to = 1;
        n_to++;
      end
      chk("svc_complete", 32'(complete), 32'(exp_c));
      chk("svc_iderr", 32'(id_err), 32'(m == jmis));
      chk("svc_busy2", 32'(busy), 1);
      chk("svc_timeout", 32'(timeout), 32'(exp_to));
      if (exp_c) begin
        chk("complete_id", 32'(complete_id), 32'(fid));
        break;
      end
    end
    tick();
    chk("post_complete", 32'(complete), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  // Offer withdrawn by dropping irq or changing the winning ID
  task automatic withdraw(input int id, input bit by_id, input int hold);
    irq = 1;
    irq_id = (W+1)'(id);
    for (int k = 0; k <= S; k++) begin
      tick();
      chk("wd_valid", 32'(core_if.req_valid_o), 32'(k == S));
    end
    for (int r = 0; r < hold; r++) begin
      tick();
      chk("wd_hold", 32'(core_if.req_valid_o), 1);
    end
    if (by_id) irq_id = (W+1)'((id % 31) + 1);
    else irq = 0;
    tick();
    chk("wd_drop", 32'(core_if.req_valid_o), 0);
    chk("wd_noclaim", 32'(claim), 0);
    irq = 0;
    irq_id = '0;
    tick();
    chk_idle_outputs("wd_after");
  endtask

  // Single-cycle irq glitch never reaches the core
  task automatic pulse(input int id);
    irq = 1;
    irq_id = (W+1)'(id);
    tick();
    irq = 0;
    irq_id = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_idle_outputs("pulse");
    end
  endtask

  initial begin
    int id;
    int jd;
    int jm;
    rst_n = 1;
    irq = 0;
    irq_id = '0;
    core_if.req_ready_i = 0;
    core_if.done_valid_i = 0;
    core_if.done_id_i = '0;
    #3 rst_n = 0;
    tick();
    tick();
    chk_idle_outputs("reset");
    chk("reset_timeout", 32'(timeout), 0);
    chk("reset_req_id", 32'(core_if.req_id_o), 0);
    chk("reset_claim_id", 32'(claim_id), 0);
    chk("reset_complete_id", 32'(complete_id), 0);
    rst_n = 1;
    tick();

    txn(5, 0, 0, 0, 0, 0, 3);
    txn(5, 7, 1, 0, 0, 0, 1);
    pulse(6);
    withdraw(11, 0, 2);
    withdraw(12, 1, 0);
    txn(13, 0, 0, 2, 1, 0, 5);
    txn(9, 0, 0, 1, 0, 2, 0);
    chk("timeout_sticky", 32'(timeout), 1);
    txn(10, 0, 0, 0, 0, 0, T);
    chk("timeout_still", 32'(timeout), 1);

    // reset during service: outputs clear at once, no complete
    irq = 1;
    irq_id = 6'd4;
    repeat (S + 1) tick();
    core_if.req_ready_i = 1;
    tick();
    core_if.req_ready_i = 0;
    irq = 0;
    irq_id = '0;
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_timeout", 32'(timeout), 0);
    exp_to = 0;
    n_claim = 0;
    n_to = 0;
    tick();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle_outputs("post_rst");
    end

    for (int i = 0; i < 20; i++) begin
      id = $urandom_range(1, 31);
      jd = $urandom_range(0, T);
      jm = $urandom_range(0, T - 1);
      if (jm == jd) jm = 0;
      txn(id, (id % 31) + 1, $urandom_range(0, S),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), jm, jd);
      if ($urandom_range(0, 3) == 0) pulse($urandom_range(1, 31));
      if ($urandom_range(0, 3) == 0)
        withdraw($urandom_range(1, 31), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2));
    end

`ifdef RV_PLIC_DISPATCH_STATS_EN
    chk("dispatch_cnt", 32'(dispatch_cnt), 32'(n_claim));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(n_to > 255 ? 255 : n_to));
`endif
    chk("final_timeout", 32'(timeout), 32'(exp_to));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
